// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the sized data memory
package dmem_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_t;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word
   function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
      return sz == 2'b00 ? 4'b0001 << a : sz == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
      return sz == 2'b00 ? {4{d[7:0]}} : sz == 2'b01 ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
      logic [31:0] s;
      s = w >> {a, 3'b000};
      return f3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
             f3 == F3_BU ? {24'b0, s[7:0]} :
             f3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
             f3 == F3_HU ? {16'b0, s[15:0]} : w;
   endfunction

   function automatic logic f3_err(input logic [2:0] f3, input logic we, input logic [1:0] a);
      logic bad;
      bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && f3[2]);
      return bad || (f3[1:0] == 2'b01 && a[0]) || (f3 == F3_W && |a);
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word RAM with byte-lane write enables and combinational read
module dmem_bank #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [3:0]        be,
   input  logic [ADDR_W-3:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**(ADDR_W-2)];

   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: RV32I-sized data memory with valid/ready request and wait states
module dmem_sized
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 0,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   state_t st, st_nx;
   logic [CNT_W-1:0] cnt;
   logic we_q;
   logic [2:0] f3_q;
   logic [31:0] addr_q, wdata_q, rword;
   logic access, err;

   assign req_ready = st == IDLE;
   assign rsp_valid = st == RESP;
   assign access = st == BUSY && cnt == '0;
   assign err = f3_err(f3_q, we_q, addr_q[1:0]) || |addr_q[31:ADDR_W];

   always_comb begin
      st_nx = st;
      if (st == IDLE && req_valid) st_nx = BUSY;
      else if (access) st_nx = RESP;
      else if (st == RESP) st_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st <= IDLE;
         cnt <= '0;
         we_q <= 1'b0;
         f3_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
      end else begin
         st <= st_nx;
         if (req_ready && req_valid) begin
            we_q <= req_we;
            f3_q <= req_funct3;
            addr_q <= req_addr;
            wdata_q <= req_wdata;
            cnt <= CNT_W'(WAIT_STATES);
         end else if (st == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            rsp_err <= err;
            rsp_rdata <= (err || we_q) ? '0 : load_ext(f3_q, addr_q[1:0], rword);
         end
      end

   // the store commits on the access edge only, so a reset before then drops it
   dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .we    (access && we_q && !err),
      .be    (lane_mask(f3_q[1:0], addr_q[1:0])),
      .idx   (addr_q[ADDR_W-1:2]),
      .wdata (store_data(f3_q[1:0], wdata_q)),
      .rdata (rword)
   );

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: table-driven scoreboard bench for dmem_sized
module tb_dmem_sized;
   import dmem_pkg::*;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   logic clk, rst, req_valid, req_we;
   logic [2:0] req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic rdy3, vld3, er3, rdy0, vld0, er0, rdy5, vld5, er5;
   logic [31:0] rd3, rd0, rd5;

   int total = 0;
   int bad = 0;
   logic [32:0] exp_q[$];
   vec_t tv[$];

   dmem_sized #(.ADDR_W(8), .WAIT_STATES(3), .CNT_W(4)) dut3 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(vld3), .rsp_rdata(rd3), .rsp_err(er3));
   dmem_sized #(.ADDR_W(8), .WAIT_STATES(0), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(vld0), .rsp_rdata(rd0), .rsp_err(er0));
   dmem_sized #(.ADDR_W(8), .WAIT_STATES(5), .CNT_W(4)) dut5 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy5), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(vld5), .rsp_rdata(rd5), .rsp_err(er5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk)
      if (vld3) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rdata %h err %b want no response", rd3, er3);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            chk("rsp_rdata", rd3, e[32:1]);
            chk("rsp_err", {31'b0, er3}, {31'b0, e[0]});
         end
      end

   task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = d;
   endtask

   task automatic xfer(input vec_t v);
      int n = 0;
      while (!rdy3 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) chk("ready_timeout", {31'b0, rdy3}, 32'd1);
      drive(v.we, v.f3, v.addr, v.wdata);
      exp_q.push_back({v.rd, v.err});
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 40) begin
         chk("rsp_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      int f0, f3v, f5, n0, n5, r0, r5;
      rst = 1'b0;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_funct3 = '0;
      req_addr = '0;
      req_wdata = '0;
      #12;
      chk("reset_ready", {31'b0, rdy3}, 32'd1);
      chk("reset_valid", {31'b0, vld3}, 32'd0);
      chk("reset_rdata", rd3, 32'd0);
      chk("reset_err", {31'b0, er3}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // store in flight is discarded by reset
      xfer('{1'b1, F3_W, 32'h10, 32'h12345678, 32'h0, 1'b0});
      xfer('{1'b0, F3_W, 32'h10, 32'h0, 32'h12345678, 1'b0});
      drive(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      chk("busy_ready", {31'b0, rdy3}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'b0, rdy3}, 32'd1);
      chk("rst_valid", {31'b0, vld3}, 32'd0);
      chk("rst_rdata", rd3, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      xfer('{1'b0, F3_W, 32'h10, 32'h0, 32'h12345678, 1'b0});

      tv.push_back('{1'b1, F3_W,  32'h20, 32'h11223344, 32'h0, 1'b0});
      tv.push_back('{1'b1, F3_B,  32'h21, 32'h000000AB, 32'h0, 1'b0});
      tv.push_back('{1'b0, F3_W,  32'h20, 32'h0, 32'h1122AB44, 1'b0});
      tv.push_back('{1'b0, F3_B,  32'h21, 32'h0, 32'hFFFFFFAB, 1'b0});
      tv.push_back('{1'b0, F3_BU, 32'h21, 32'h0, 32'h000000AB, 1'b0});
      tv.push_back('{1'b1, F3_W,  32'h30, 32'hCAFE5A5A, 32'h0, 1'b0});
      tv.push_back('{1'b1, F3_H,  32'h32, 32'h00008001, 32'h0, 1'b0});
      tv.push_back('{1'b0, F3_H,  32'h32, 32'h0, 32'hFFFF8001, 1'b0});
      tv.push_back('{1'b0, F3_HU, 32'h32, 32'h0, 32'h00008001, 1'b0});
      tv.push_back('{1'b0, F3_W,  32'h30, 32'h0, 32'h80015A5A, 1'b0});
      tv.push_back('{1'b1, F3_B,  32'h23, 32'h00000080, 32'h0, 1'b0});
      tv.push_back('{1'b0, F3_B,  32'h23, 32'h0, 32'hFFFFFF80, 1'b0});
      tv.push_back('{1'b0, F3_H,  32'h20, 32'h0, 32'hFFFFAB44, 1'b0});
      tv.push_back('{1'b0, F3_HU, 32'h22, 32'h0, 32'h00008022, 1'b0});
      tv.push_back('{1'b1, F3_W,  32'h04, 32'h01020304, 32'h0, 1'b0});
      tv.push_back('{1'b0, F3_H,  32'h05, 32'h0, 32'h0, 1'b1});
      tv.push_back('{1'b1, F3_W,  32'h06, 32'hFFFFFFFF, 32'h0, 1'b1});
      tv.push_back('{1'b1, F3_H,  32'h05, 32'h0000FFFF, 32'h0, 1'b1});
      tv.push_back('{1'b1, F3_W,  32'h104, 32'h00000BAD, 32'h0, 1'b1});
      tv.push_back('{1'b0, F3_W,  32'h100, 32'h0, 32'h0, 1'b1});
      tv.push_back('{1'b0, 3'b011, 32'h04, 32'h0, 32'h0, 1'b1});
      tv.push_back('{1'b1, 3'b100, 32'h04, 32'h000000FF, 32'h0, 1'b1});
      tv.push_back('{1'b1, 3'b111, 32'h04, 32'h000000FF, 32'h0, 1'b1});
      tv.push_back('{1'b0, F3_W,  32'h04, 32'h0, 32'h01020304, 1'b0});
      tv.push_back('{1'b0, F3_W,  32'h80000004, 32'h0, 32'h0, 1'b1});
      tv.push_back('{1'b0, F3_BU, 32'h07, 32'h0, 32'h00000001, 1'b0});
      tv.push_back('{1'b0, F3_HU, 32'h06, 32'h0, 32'h00000102, 1'b0});
      tv.push_back('{1'b1, F3_W,  32'h24, 32'h55AA55AA, 32'h0, 1'b0});
      tv.push_back('{1'b1, F3_W,  32'h28, 32'h00000066, 32'h0, 1'b0});
      tv.push_back('{1'b1, F3_B,  32'hFF, 32'h0000005A, 32'h0, 1'b0});
      tv.push_back('{1'b0, F3_BU, 32'hFF, 32'h0, 32'h0000005A, 1'b0});
      for (int i = 0; i < tv.size(); i++) xfer(tv[i]);

      // back-pressure: changing stores held while busy must be ignored
      drive(1'b0, F3_W, 32'h20, 32'h0);
      exp_q.push_back({32'h8022AB44, 1'b0});
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         drive(1'b1, F3_W, 32'h24 + 32'(4 * (i % 2)), 32'hEEEE0000 + 32'(i));
      end
      @(posedge clk); #1;
      chk("bp_ready", {31'b0, rdy3}, 32'd1);
      drive(1'b0, F3_W, 32'h04, 32'h0);
      exp_q.push_back({32'h01020304, 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
      end
      chk("bp_drain", exp_q.size(), 32'd0);
      exp_q.delete();
      xfer('{1'b0, F3_W, 32'h24, 32'h0, 32'h55AA55AA, 1'b0});
      xfer('{1'b0, F3_W, 32'h28, 32'h0, 32'h00000066, 1'b0});

      // latency of three wait-state settings from one shared acceptance edge
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, F3_W, 32'h20, 32'h0);
      exp_q.push_back({32'h8022AB44, 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      f0 = 0; f3v = 0; f5 = 0; n0 = 0; n5 = 0; r0 = 0; r5 = 0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (vld0) begin n0++; if (f0 == 0) f0 = k; end
         if (vld5) begin n5++; if (f5 == 0) f5 = k; end
         if (vld3 && f3v == 0) f3v = k;
         if (!rdy0) r0++;
         if (!rdy5) r5++;
      end
      chk("lat_ws0", f0, 32'd1);
      chk("lat_ws3", f3v, 32'd4);
      chk("lat_ws5", f5, 32'd6);
      chk("len_ws0", n0, 32'd1);
      chk("len_ws5", n5, 32'd1);
      chk("busy_ws0", r0, 32'd1);
      chk("busy_ws5", r5, 32'd6);
      chk("lat_drain", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
